// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// No logic here; consumers import ps2_pkg::*.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_REL = 8'hF0;
  localparam int         DATA_BITS  = 8;

  // Odd parity: data byte plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fall_detect.sv
// Purpose: strobe on a high-to-low transition of the debounced PS/2 clock.
// Latency: strobe is combinational in the cycle the low level is first seen.
// Backpressure: none; free-running edge detector.
module ps2_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  output logic fall
);

  logic prev;

  // Reset to 1 so a line that is already low does not look like a fall.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= ps2_clk;
  end

  assign fall = prev & ~ps2_clk;

endmodule

// File: rtl/ps2_receiver.sv
// Purpose: decode PS/2 keyboard frames into scan codes with E0/F0 prefix flags.
// Latency: code_valid/parity_err/frame_err pulse one cycle after the stop-bit fall.
// Backpressure: none; the keyboard cannot be stalled, consumers must take each pulse.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       released,   // "release" is a reserved word in SystemVerilog
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  ps2_state_t  state, state_nxt;
  logic        fall;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        par_bit;
  logic [15:0] to_cnt;
  logic        ext_flag, rel_flag;
  logic        timeout, byte_done, par_fail, stop_fail;

  ps2_fall_detect u_fall (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .fall    (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A fall always takes priority over an expiring timeout.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    byte_done = 1'b0;
    par_fail  = 1'b0;
    stop_fail = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE:   if (!ps2_data) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (!ps2_data)                         stop_fail = 1'b1;
          else if (!odd_parity_ok(shreg, par_bit)) par_fail  = 1'b1;
          else                                   byte_done = 1'b1;
        end
        default:   state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
      timeout   = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      ext_flag   <= 1'b0;
      rel_flag   <= 1'b0;
      scan_code  <= '0;
      extended   <= 1'b0;
      released   <= 1'b0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= par_fail;
      frame_err  <= stop_fail | timeout;

      if (fall || timeout || state == ST_IDLE) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + 16'd1;

      if (fall) begin
        case (state)
          ST_IDLE: bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {ps2_data, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_bit <= ps2_data;
          default: ;
        endcase
      end

      // Prefix flags only survive into the very next good byte.
      if (par_fail || stop_fail || timeout) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (byte_done) begin
        if (shreg == PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg == PREFIX_REL) begin
          rel_flag <= 1'b1;
        end else begin
          scan_code  <= shreg;
          extended   <= ext_flag;
          released   <= rel_flag;
          code_valid <= 1'b1;
          ext_flag   <= 1'b0;
          rel_flag   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed plus randomized frames against a byte-level model of the PS/2 decoder.
module tb_ps2_receiver;

  localparam int TO   = 50000;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       extended;
  logic       released;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;

  ps2_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .extended   (extended),
    .released   (released),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cv = 0, n_pe = 0, n_fe = 0;
  int e_cv = 0, e_pe = 0, e_fe = 0;

  logic [7:0] m_sc      = 8'h00;
  logic       m_ext_out = 1'b0;
  logic       m_rel_out = 1'b0;
  logic       m_ext     = 1'b0;
  logic       m_rel     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count pulses; a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (code_valid === 1'b1 || parity_err === 1'b1 || frame_err === 1'b1) begin
      check("one_hot", 32'($countones({code_valid, parity_err, frame_err})), 32'd1);
      if (code_valid === 1'b1) n_cv++;
      if (parity_err === 1'b1) n_pe++;
      if (frame_err  === 1'b1) n_fe++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_pulse(input logic d);
    ps2_data = d;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    clk_pulse(1'b0);
    for (int i = 0; i < 8; i++) clk_pulse(b[i]);
    clk_pulse((~^b) ^ par_flip);
    clk_pulse(stop);
    ps2_data = 1'b1;
    cyc(6);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    if (!stop) begin
      e_fe++; m_ext = 1'b0; m_rel = 1'b0;
    end else if (par_flip) begin
      e_pe++; m_ext = 1'b0; m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      e_cv++;
      m_sc = b; m_ext_out = m_ext; m_rel_out = m_rel;
      m_ext = 1'b0; m_rel = 1'b0;
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_cv_cnt"}, 32'(n_cv), 32'(e_cv));
    check({tag, "_pe_cnt"}, 32'(n_pe), 32'(e_pe));
    check({tag, "_fe_cnt"}, 32'(n_fe), 32'(e_fe));
    check({tag, "_scan"},   32'(scan_code), 32'(m_sc));
    check({tag, "_ext"},    32'(extended),  32'(m_ext_out));
    check({tag, "_rel"},    32'(released),  32'(m_rel_out));
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input logic par_flip, input logic stop);
    send_frame(b, par_flip, stop);
    model_frame(b, par_flip, stop);
    verify(tag);
  endtask

  initial begin
    logic [7:0] rb;
    int         r;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    verify("reset");
    check("reset_cv", 32'(code_valid), 32'd0);
    check("reset_pe", 32'(parity_err), 32'd0);
    check("reset_fe", 32'(frame_err),  32'd0);

    frame("plain_1c", 8'h1C, 1'b0, 1'b1);

    frame("rel_pre", 8'hF0, 1'b0, 1'b1);
    frame("rel_1c",  8'h1C, 1'b0, 1'b1);

    frame("ext_e0",  8'hE0, 1'b0, 1'b1);
    frame("ext_f0",  8'hF0, 1'b0, 1'b1);
    frame("ext_74",  8'h74, 1'b0, 1'b1);
    frame("plain_74", 8'h74, 1'b0, 1'b1);

    frame("bad_par", 8'h1C, 1'b1, 1'b1);

    frame("stop_pre", 8'hE0, 1'b0, 1'b1);
    frame("bad_stop", 8'h33, 1'b0, 1'b0);
    frame("after_stop", 8'h21, 1'b0, 1'b1);

    // A fall with data high in idle is not a start bit.
    clk_pulse(1'b1);
    ps2_data = 1'b1;
    cyc(6);
    verify("idle_high");
    frame("after_idle", 8'h1C, 1'b0, 1'b1);

    // Timeout mid-frame drops the byte and the pending E0.
    frame("to_pre", 8'hE0, 1'b0, 1'b1);
    clk_pulse(1'b0);
    clk_pulse(1'b0);
    clk_pulse(1'b1);
    clk_pulse(1'b1);
    ps2_data = 1'b1;
    cyc(TO - 20);
    verify("pre_timeout");
    cyc(40);
    e_fe++; m_ext = 1'b0; m_rel = 1'b0;
    verify("timeout");
    frame("after_to", 8'h1C, 1'b0, 1'b1);

    // Reset in the middle of a frame discards it silently.
    frame("rst_pre", 8'hF0, 1'b0, 1'b1);
    clk_pulse(1'b0);
    for (int i = 0; i < 5; i++) clk_pulse(1'b1);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    ps2_data = 1'b1;
    cyc(2);
    m_sc = 8'h00; m_ext_out = 1'b0; m_rel_out = 1'b0; m_ext = 1'b0; m_rel = 1'b0;
    verify("rst_mid");
    frame("after_rst", 8'h1C, 1'b0, 1'b1);

    for (int k = 0; k < 50; k++) begin
      r  = $urandom_range(0, 9);
      rb = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom);
      frame("rand", rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
